// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors round sequencer.
// Choice/result encodings match the game core interface.
package rps_pkg;

    typedef enum logic [1:0] {
        CH_ROCK     = 2'b00,
        CH_PAPER    = 2'b01,
        CH_SCISSORS = 2'b10,
        CH_INVALID  = 2'b11
    } choice_t;

    typedef enum logic [1:0] {
        RES_DRAW     = 2'b00,
        RES_P1_WIN   = 2'b01,
        RES_P2_WIN   = 2'b10,
        RES_CORE_ERR = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SHOW,
        ERROR
    } state_t;

    localparam logic [1:0] CHOICE_INVALID = 2'b11;

endpackage

// File: rtl/rps_debounce.sv
// Button front end: 2-flop synchronizer, stability counter and debounced level.
// press/rel are one-cycle pulses coincident with the debounced level change.
module rps_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          flip;

    // The level flips on the last of DEBOUNCE_CYCLES consecutive disagreeing cycles.
    assign flip = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= flip & sync[1];
            rel   <= flip & ~sync[1];
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rps_round_sequencer.sv
// Round sequencer: debounced start, choice latch, start/done handshake with timeout.
// Optional saturating win counters are built only when RPS_SCORE_EN is defined.
module rps_round_sequencer
    import rps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int SCORE_W         = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_btn,
    input  logic [1:0]         player1_sw,
    input  logic [1:0]         player2_sw,
    input  logic               game_done,
    input  logic [1:0]         game_result,
    output logic               game_start,
    output logic [1:0]         player1_choice,
    output logic [1:0]         player2_choice,
    output logic [1:0]         result_q,
    output logic               result_valid,
    output logic               busy,
    output logic               err,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score
);
    // state | meaning
    // IDLE  | waiting for a debounced press
    // ISSUE | one-cycle start request to the core
    // WAIT  | waiting for game_done, timeout counter running
    // SHOW  | result held for display until release
    // ERROR | invalid choice, core error or timeout; cleared by release
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_nxt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    sw_sync1, sw_sync2;
    logic          btn_level, press, rel;

    rps_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (start_btn),
        .level (btn_level),
        .press (press),
        .rel   (rel)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press) begin
                    if (sw_sync2[1:0] == CHOICE_INVALID || sw_sync2[3:2] == CHOICE_INVALID)
                        state_nxt = ERROR;
                    else
                        state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (game_done)
                    state_nxt = (game_result == RES_CORE_ERR) ? ERROR : SHOW;
                else if (to_cnt == TW'(TIMEOUT_CYCLES - 1))
                    state_nxt = ERROR;
            end
            SHOW:    if (rel) state_nxt = IDLE;
            ERROR:   if (rel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            to_cnt         <= '0;
            sw_sync1       <= '0;
            sw_sync2       <= '0;
            player1_choice <= '0;
            player2_choice <= '0;
            result_q       <= '0;
        end else begin
            state    <= state_nxt;
            sw_sync1 <= {player2_sw, player1_sw};
            sw_sync2 <= sw_sync1;
            to_cnt   <= (state == WAIT) ? to_cnt + TW'(1) : '0;
            if (state == IDLE && state_nxt == ISSUE) begin
                player1_choice <= sw_sync2[1:0];
                player2_choice <= sw_sync2[3:2];
            end
            if (state == WAIT && game_done)
                result_q <= game_result;
        end
    end

    assign game_start   = (state == ISSUE);
    assign busy         = (state == ISSUE) || (state == WAIT);
    assign result_valid = (state == SHOW);
    assign err          = (state == ERROR);

`ifdef RPS_SCORE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_score <= '0;
            p2_score <= '0;
        end else if (state == WAIT && state_nxt == SHOW) begin
            if (game_result == RES_P1_WIN && p1_score != '1)
                p1_score <= p1_score + SCORE_W'(1);
            if (game_result == RES_P2_WIN && p2_score != '1)
                p2_score <= p2_score + SCORE_W'(1);
        end
    end
`else
    assign p1_score = '0;
    assign p2_score = '0;
`endif

endmodule
